// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM state, funct3 encodings and byte-lane helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know b/h/w; loads additionally have the unsigned byte/half forms.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h000000, b};
            F3_HU:   r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Read-modify-write merge: only the addressed lane takes new data.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (f3)
            F3_B:    r[{off, 3'b000} +: 8] = wd[7:0];
            F3_H:    r[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake bundle between a core and the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_word_ram.sv
// rtl/lsu_word_ram.sv - word-wide RAM with enabled synchronous read and synchronous write
module lsu_word_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // rdata only moves when re is high, so a word read once stays visible for later cycles.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte/half/word load/store engine over a word RAM
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    lsu_state_e        state;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;

    logic              out_of_range;
    logic              req_err;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    assign out_of_range = bus.req_addr[31:2] >= 30'(DEPTH_WORDS);
    assign req_err      = out_of_range
                        | f3_illegal(bus.req_we, bus.req_funct3)
                        | misaligned(bus.req_funct3, bus.req_addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= F3_W;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        funct3_q    <= bus.req_funct3;
                        addr_q      <= bus.req_addr[AW+1:0];
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (bus.req_we && bus.req_funct3 == F3_W) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // Sub-word stores pass through READ to fetch the word they patch.
                    if (we_q) begin
                        state <= ST_WRITE;
                    end else begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram_re    = (state == ST_READ);
    assign ram_we    = (state == ST_WRITE) && !rst;
    assign ram_wdata = store_merge(funct3_q, addr_q[1:0], ram_rdata, wdata_q);

    lsu_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    // RAM output is frozen after READ, so the extended value is stable for the whole RESP.
    assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q)
                         ? load_extend(funct3_q, addr_q[1:0], ram_rdata) : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed bench for load_store_unit against a memory model
module tb_load_store_unit;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] mem_m [DEPTH];

    function automatic bit m_err(input bit we, input int f3, input logic [31:0] addr);
        logic [31:0] size;
        if ((addr >> 2) >= 32'(DEPTH)) return 1'b1;
        if (we ? (f3 > 2) : (f3 == 3 || f3 >= 6)) return 1'b1;
        size = (f3 % 4 == 0) ? 32'd1 : (f3 % 4 == 1) ? 32'd2 : 32'd4;
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input logic [31:0] addr);
        logic [31:0] w;
        logic [31:0] v;
        w = mem_m[addr[7:2]];
        v = w >> (8 * addr[1:0]);
        case (f3)
            0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            4: v = v & 32'hFF;
            5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic m_store(input int f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] sh;
        sh   = 8 * addr[1:0];
        mask = (f3 == 0) ? 32'hFF : (f3 == 1) ? 32'hFFFF : 32'hFFFFFFFF;
        mem_m[addr[7:2]] = (mem_m[addr[7:2]] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    function automatic int m_lat(input bit we, input int f3, input logic [31:0] addr);
        if (m_err(we, f3, addr)) return 1;
        if (we && f3 != 2) return 3;
        return 2;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int guard;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=%b want 1", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 50);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] rd, wd;
        logic er;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom();
            do_req(1'b1, 3'd2, 32'(i * 4), wd, rd, er, lat);
            mem_m[i] = wd;
            total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL fill_rsp[%0d]: got err=%b rdata=%h want err=0 rdata=0", i, er, rd); end
            total++; if (lat != 2) begin bad++; $display("FAIL fill_latency[%0d]: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, rd, er, lat);
        m_store(2, 32'h8, 32'hDEADBEEF);
        total++; if (er !== 1'b0 || lat != 2) begin bad++; $display("FAIL sw_0x8: got err=%b lat=%0d want err=0 lat=2", er, lat); end
        do_req(1'b0, 3'd2, 32'h8, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL lw_0x8: got %h err=%b want deadbeef err=0", rd, er); end
        total++; if (lat != 2) begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 3'd0, 32'h9, 32'hABCDEF12, rd, er, lat);
        m_store(0, 32'h9, 32'hABCDEF12);
        total++; if (er !== 1'b0 || lat != 3) begin bad++; $display("FAIL sb_0x9: got err=%b lat=%0d want err=0 lat=3", er, lat); end
        do_req(1'b0, 3'd2, 32'h8, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD12EF || rd !== m_load(2, 32'h8)) begin bad++; $display("FAIL sb_merge: got %h want dead12ef", rd); end
        do_req(1'b0, 3'd0, 32'h9, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00000012) begin bad++; $display("FAIL lb_0x9: got %h want 00000012", rd); end
        do_req(1'b0, 3'd4, 32'hB, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h000000DE) begin bad++; $display("FAIL lbu_0xB: got %h want 000000de", rd); end
        do_req(1'b0, 3'd0, 32'hB, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFFFFDE || lat != 2) begin bad++; $display("FAIL lb_0xB: got %h lat=%0d want ffffffde lat=2", rd, lat); end
        do_req(1'b1, 3'd1, 32'hA, 32'h12348001, rd, er, lat);
        m_store(1, 32'hA, 32'h12348001);
        total++; if (er !== 1'b0 || lat != 3) begin bad++; $display("FAIL sh_0xA: got err=%b lat=%0d want err=0 lat=3", er, lat); end
        do_req(1'b0, 3'd1, 32'hA, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh_0xA: got %h want ffff8001", rd); end
        do_req(1'b0, 3'd5, 32'hA, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu_0xA: got %h want 00008001", rd); end
        do_req(1'b0, 3'd2, 32'h8, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h800112EF) begin bad++; $display("FAIL sh_merge: got %h want 800112ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        logic [2:0]  e_f3   [4] = '{3'd1, 3'd2, 3'd2, 3'd3};
        logic        e_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_addr [4] = '{32'h1, 32'h6, 32'h100, 32'h4};
        for (int i = 0; i < 4; i++) begin
            do_req(e_we[i], e_f3[i], e_addr[i], 32'hCAFEF00D, rd, er, lat);
            total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_case[%0d]: got err=%b rdata=%h want err=1 rdata=0", i, er, rd); end
            total++; if (lat != 1) begin bad++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
        end
        do_req(1'b0, 3'd2, 32'h4, 32'h0, rd, er, lat);
        total++; if (rd !== mem_m[1]) begin bad++; $display("FAIL err_no_write_0x4: got %h want %h", rd, mem_m[1]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_rd;
        logic er;
        bit we, exp_er;
        int f3, lat;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = int'($urandom_range(0, 7));
            addr = ($urandom_range(0, 7) == 0) ? 32'h100 + $urandom_range(0, 4000) : $urandom_range(0, 255);
            wd   = $urandom();
            exp_er = m_err(we, f3, addr);
            exp_rd = (exp_er || we) ? 32'h0 : m_load(f3, addr);
            do_req(we, 3'(f3), addr, wd, rd, er, lat);
            if (we && !exp_er) m_store(f3, addr, wd);
            total++; if (er !== exp_er) begin bad++; $display("FAIL rand_err[%0d] we=%0d f3=%0d a=%h: got %b want %b", n, we, f3, addr, er, exp_er); end
            total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d] we=%0d f3=%0d a=%h: got %h want %h", n, we, f3, addr, rd, exp_rd); end
            total++; if (lat != m_lat(we, f3, addr)) begin bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, m_lat(we, f3, addr)); end
        end
        for (int i = 0; i < DEPTH; i += 9) begin
            do_req(1'b0, 3'd2, 32'(i * 4), 32'h0, rd, er, lat);
            total++; if (rd !== mem_m[i]) begin bad++; $display("FAIL rand_readback[%0d]: got %h want %h", i, rd, mem_m[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, rd0, exp0;
        logic er;
        int lat, guard;
        exp0 = mem_m[4];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_we = 1'b1; bus.req_addr = 32'h14; bus.req_wdata = 32'h5A5A1234;
        guard = 0;
        do begin @(negedge clk); guard++; end while (bus.rsp_valid !== 1'b1 && guard < 50);
        total++; if (guard != 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", guard); end
        rd0 = bus.rsp_rdata;
        total++; if (rd0 !== exp0) begin bad++; $display("FAIL bp_rdata: got %h want %h", rd0, exp0); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h want valid=1 rdata=%h", k, bus.rsp_valid, bus.rsp_rdata, rd0); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d]: got %b want 0", k, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", bus.rsp_valid, bus.req_ready); end
        do_req(1'b1, 3'd2, 32'h14, 32'h5A5A1234, rd, er, lat);
        m_store(2, 32'h14, 32'h5A5A1234);
        total++; if (er !== 1'b0 || lat != 2) begin bad++; $display("FAIL bp_held_sw: got err=%b lat=%0d want err=0 lat=2", er, lat); end
        do_req(1'b0, 3'd2, 32'h14, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h5A5A1234) begin bad++; $display("FAIL bp_held_readback: got %h want 5a5a1234", rd); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        logic er;
        int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h000000A5; bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midwrite_reset: got ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.rsp_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 3'd2, 32'h4, 32'h0, rd, er, lat);
        total++; if (rd !== mem_m[1] || er !== 1'b0) begin bad++; $display("FAIL midwrite_word_0x4: got %h want %h", rd, mem_m[1]); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word();
        test_subword();
        test_errors();
        test_random();
        test_backpressure();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit data words.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I load/store funct3.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data (rs2 value), low bytes used for sb/sh.
REQ-010 SHALL have port rsp_valid, output, 1, response present.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-012 SHALL have port rsp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1, misaligned, out-of-range or illegal funct3.

Function
REQ-014 SHALL accept a request on a cycle where req_valid and req_ready are both 1, capturing addr, funct3, wdata, we.
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL transition IDLE->RESP on an erroneous request, IDLE->WRITE for sw, IDLE->READ for every load and for sb/sh.
REQ-017 SHALL transition READ->RESP for loads and READ->WRITE for sb/sh (read-modify-write).
REQ-018 SHALL transition WRITE->RESP, and RESP->IDLE only when rsp_ready=1; RESP holds rsp_rdata/rsp_err stable otherwise.
REQ-019 SHALL give latencies from accept to first rsp_valid: lw/lb/lh/lbu/lhu 2 cycles, sw 2 cycles, sb/sh 3 cycles, error 1 cycle.
REQ-020 SHALL index RAM by req_addr[31:2]; an index >= DEPTH_WORDS is out-of-range.
REQ-021 SHALL flag misalignment: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; byte accesses never misaligned.
REQ-022 SHALL treat funct3 values 011, 110, 111 for loads and any value other than 000/001/010 for stores as illegal.
REQ-023 SHALL perform no RAM write for any erroneous request; rsp_err=1, rsp_rdata=0.
REQ-024 SHALL select byte addr[1:0] for lb/lbu and halfword addr[1] for lh/lhu; lb/lh sign-extend, lbu/lhu zero-extend, lw returns full word.
REQ-025 SHALL merge sb/sh data into only the addressed byte/halfword of the word read in READ, leaving other bytes unchanged.
REQ-026 SHALL issue a RAM read only in READ, so RAM read data stays stable through RESP.
REQ-027 SHALL ignore req_valid outside IDLE; a request held across a busy period is accepted on return to IDLE.

Reset
REQ-028 SHALL on rst=1 immediately force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-029 SHALL abort any in-flight operation on reset; no RAM write occurs on any edge where rst=1.
REQ-030 SHALL NOT clear RAM contents on reset.

Structure
REQ-031 SHALL place the FSM state enum and load/store funct3 constants in shared package lsu_pkg.
REQ-032 SHALL instantiate one sub-module lsu_word_ram: DEPTH_WORDS x 32, synchronous read with read enable (data valid next cycle, held otherwise), synchronous full-word write.

Verification
REQ-033 SHALL test sw addr 0x8 data 0xDEADBEEF, then lw 0x8 -> rsp_rdata 0xDEADBEEF, err 0, each response 2 cycles after accept.
REQ-034 SHALL test word 0x8=0xDEADBEEF then sb 0x9 data 0x12 -> word 0xDEAD12EF; lb 0x9 -> 0x00000012; lbu 0xB -> 0x000000DE; lb 0xB -> 0xFFFFFFDE.
REQ-035 SHALL test lh 0x1 and sw 0x6 -> rsp_err 1 one cycle after accept, rdata 0, memory unchanged.
REQ-036 SHALL test lw 0x100 with DEPTH_WORDS=64 -> rsp_err 1; store funct3 011 -> rsp_err 1.
REQ-037 SHALL test rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready 0, new req_valid ignored until acceptance.
REQ-038 SHALL test rst asserted during WRITE of sb 0x4 -> IDLE same cycle, rsp_valid 0, word 0x4 unchanged.
